pcs_rx_link_sequencer: RTL and testbench



---
 rtl/pcs_rx_pkg.sv | 75 +++++++
 rtl/pcs_seq_timer.sv | 43 ++++
 rtl/pcs_rx_link_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pcs_rx_link_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_rx_pkg
//  Description : Shared types and constants for the PCS RX link sequencer:
//                state encoding, settle-count default and the state-to-output
//                decode used to drive the registered stage enables.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcs_rx_pkg;

  localparam int NB_STATE              = 3;
  localparam int DESKEW_SETTLE_DEFAULT = 64;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE    = 3'd0,
    ST_BSYNC   = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_DESKEW  = 3'd3,
    ST_REORDER = 3'd4,
    ST_UP      = 3'd5,
    ST_BACKOFF = 3'd6
  } state_e;

  typedef struct packed {
    logic block_sync;
    logic aligner;
    logic deskewer;
    logic lane_reorder;
    logic reset_order;
    logic descrambler;
    logic decoder;
    logic link_up;
  } stage_out_t;

  // Enables are cumulative in pipeline order; IDLE, BACKOFF and any unused
  // encoding leave every stage disabled.
  function automatic stage_out_t decode_state(input state_e s);
    stage_out_t o;
    o = '0;
    case (s)
      ST_BSYNC: begin
        o.block_sync = 1'b1;
      end
      ST_ALIGN: begin
        o.block_sync = 1'b1;
        o.aligner    = 1'b1;
      end
      ST_DESKEW: begin
        o.block_sync = 1'b1;
        o.aligner    = 1'b1;
        o.deskewer   = 1'b1;
      end
      ST_REORDER: begin
        o.block_sync   = 1'b1;
        o.aligner      = 1'b1;
        o.deskewer     = 1'b1;
        o.lane_reorder = 1'b1;
        o.reset_order  = 1'b1;
      end
      ST_UP: begin
        o.block_sync   = 1'b1;
        o.aligner      = 1'b1;
        o.deskewer     = 1'b1;
        o.lane_reorder = 1'b1;
        o.descrambler  = 1'b1;
        o.decoder      = 1'b1;
        o.link_up      = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_seq_timer
//  Description : Up-counter with synchronous clear (priority) and count
//                enable, plus an equality flag against a compare value.
//                The flag reflects the registered count, so the value seen
//                on a given edge is the number of enabled cycles since the
//                last clear, minus the cycle of the clear itself.
//  Ports       : i_clock   - clock
//                i_reset   - asynchronous active-low reset
//                i_clear   - load zero (wins over i_enable)
//                i_enable  - increment by one
//                i_compare - compare value
//                o_equal   - count == i_compare
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_compare,
  output logic             o_equal
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_equal = (r_count == i_compare);

endmodule
`default_nettype wire

// File: rtl/pcs_rx_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_rx_link_sequencer
//  Description : Bring-up / recovery controller for the 100GbE PCS RX chain.
//                Enables block sync, aligner, deskewer, lane reorder and
//                descrambler/decoder one stage at a time, with per-stage
//                timeout, fault detection, retry/backoff and retry stats.
//  Ports       : i_clock, i_reset (async active-low)
//                i_enable              - 0 forces IDLE
//                i_rf_stage_timeout    - cycles per wait stage (0 = off)
//                i_rf_backoff_cycles   - BACKOFF length control
//                i_rf_clear_retry      - clears o_retry_count
//                i_lanes_block_lock, i_am_lock, i_invalid_skew, i_hi_ber
//                                      - RX status
//                o_enable_*            - registered stage enables
//                o_reset_order         - one-cycle pulse in REORDER
//                o_link_up, o_state, o_retry_count
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_rx_link_sequencer #(
  parameter int N_LANES       = 20,
  parameter int NB_TIMEOUT    = 24,
  parameter int NB_BACKOFF    = 16,
  parameter int NB_RETRY      = 8,
  parameter int DESKEW_SETTLE = pcs_rx_pkg::DESKEW_SETTLE_DEFAULT,
  parameter int NB_STATE      = pcs_rx_pkg::NB_STATE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [NB_TIMEOUT-1:0] i_rf_stage_timeout,
  input  logic [NB_BACKOFF-1:0] i_rf_backoff_cycles,
  input  logic                  i_rf_clear_retry,
  input  logic [N_LANES-1:0]    i_lanes_block_lock,
  input  logic [N_LANES-1:0]    i_am_lock,
  input  logic                  i_invalid_skew,
  input  logic [N_LANES-1:0]    i_hi_ber,
  output logic                  o_enable_block_sync,
  output logic                  o_enable_aligner,
  output logic                  o_enable_deskewer,
  output logic                  o_enable_lane_reorder,
  output logic                  o_reset_order,
  output logic                  o_enable_descrambler,
  output logic                  o_enable_decoder,
  output logic                  o_link_up,
  output logic [NB_STATE-1:0]   o_state,
  output logic [NB_RETRY-1:0]   o_retry_count
);

  import pcs_rx_pkg::*;

  localparam int                  c_nb_settle    = $clog2(DESKEW_SETTLE + 1);
  localparam logic [c_nb_settle-1:0] c_settle_last = c_nb_settle'(DESKEW_SETTLE - 1);
  localparam logic [NB_RETRY-1:0] c_retry_max    = '1;

  state_e               r_state;
  state_e               w_next;
  stage_out_t           r_out;
  logic [NB_RETRY-1:0]  r_retry;

  logic w_all_block;
  logic w_all_am;
  logic w_any_hi_ber;
  logic w_stage_eq;
  logic w_settle_eq;
  logic w_backoff_eq;
  logic w_timeout;
  logic w_changing;
  logic w_stage_run;
  logic w_backoff_entry;

  assign w_all_block  = &i_lanes_block_lock;
  assign w_all_am     = &i_am_lock;
  assign w_any_hi_ber = |i_hi_ber;
  assign w_timeout    = (i_rf_stage_timeout != '0) && w_stage_eq;
  assign w_stage_run  = (r_state == ST_BSYNC) || (r_state == ST_ALIGN) ||
                        (r_state == ST_DESKEW);

  // Every counter restarts from zero when the state it serves is entered.
  assign w_changing      = (w_next != r_state);
  assign w_backoff_entry = (w_next == ST_BACKOFF) && (r_state != ST_BACKOFF);

  // --------------------------------------------------------------------------
  // Next-state decision. Within a stage: fault beats advance, advance beats
  // timeout. Dropping i_enable overrides everything.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next = ST_BSYNC;
        end
        ST_BSYNC: begin
          if (w_all_block)    w_next = ST_ALIGN;
          else if (w_timeout) w_next = ST_BACKOFF;
        end
        ST_ALIGN: begin
          if (!w_all_block)   w_next = ST_BACKOFF;
          else if (w_all_am)  w_next = ST_DESKEW;
          else if (w_timeout) w_next = ST_BACKOFF;
        end
        ST_DESKEW: begin
          if (!w_all_block || !w_all_am)          w_next = ST_BACKOFF;
          else if (w_settle_eq && !i_invalid_skew) w_next = ST_REORDER;
          else if (w_timeout)                      w_next = ST_BACKOFF;
        end
        ST_REORDER: begin
          if (!w_all_block) w_next = ST_BACKOFF;
          else              w_next = ST_UP;
        end
        ST_UP: begin
          if (!w_all_block || !w_all_am || i_invalid_skew || w_any_hi_ber)
            w_next = ST_BACKOFF;
        end
        ST_BACKOFF: begin
          if (w_backoff_eq) w_next = ST_BSYNC;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  pcs_seq_timer #(.WIDTH(NB_TIMEOUT)) u_stage_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_changing),
    .i_enable  (w_stage_run),
    .i_compare (i_rf_stage_timeout),
    .o_equal   (w_stage_eq)
  );

  // A skew violation restarts the settle window from zero.
  pcs_seq_timer #(.WIDTH(c_nb_settle)) u_settle_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_changing || i_invalid_skew),
    .i_enable  (r_state == ST_DESKEW),
    .i_compare (c_settle_last),
    .o_equal   (w_settle_eq)
  );

  pcs_seq_timer #(.WIDTH(NB_BACKOFF)) u_backoff_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_changing),
    .i_enable  (r_state == ST_BACKOFF),
    .i_compare (i_rf_backoff_cycles),
    .o_equal   (w_backoff_eq)
  );

  // --------------------------------------------------------------------------
  // State, registered outputs and retry statistics. Outputs are decoded from
  // the next state so they change on the same edge as the state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= decode_state(w_next);
      if (i_rf_clear_retry) begin
        r_retry <= '0;
      end else if (w_backoff_entry && (r_retry != c_retry_max)) begin
        r_retry <= r_retry + NB_RETRY'(1);
      end
    end
  end

  assign o_enable_block_sync   = r_out.block_sync;
  assign o_enable_aligner      = r_out.aligner;
  assign o_enable_deskewer     = r_out.deskewer;
  assign o_enable_lane_reorder = r_out.lane_reorder;
  assign o_reset_order         = r_out.reset_order;
  assign o_enable_descrambler  = r_out.descrambler;
  assign o_enable_decoder      = r_out.decoder;
  assign o_link_up             = r_out.link_up;
  assign o_state               = NB_STATE'(r_state);
  assign o_retry_count         = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pcs_rx_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcs_rx_link_sequencer
//  Description : Directed self-checking bench for pcs_rx_link_sequencer.
//                Timing model: state entered on edge E; counters see k-1 on
//                edge E+k, so a compare value T leaves after T+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_rx_link_sequencer;

  localparam int N = 20;
  localparam logic [N-1:0] ALL  = '1;
  localparam logic [N-1:0] MISS = 20'hFFFFE;

  localparam logic [7:0] E_OFF     = 8'h00;
  localparam logic [7:0] E_BSYNC   = 8'h80;
  localparam logic [7:0] E_ALIGN   = 8'hC0;
  localparam logic [7:0] E_DESKEW  = 8'hE0;
  localparam logic [7:0] E_REORDER = 8'hF8;
  localparam logic [7:0] E_UP      = 8'hF7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [23:0]   tmo;
  logic [15:0]   bko;
  logic          clr;
  logic [N-1:0]  blk;
  logic [N-1:0]  am;
  logic          skew;
  logic [N-1:0]  hiber;

  logic          o_bs, o_al, o_ds, o_ro, o_rsto, o_dsc, o_dec, o_up;
  logic [2:0]    o_state;
  logic [7:0]    o_retry;
  logic [7:0]    outs;

  int checks   = 0;
  int failures = 0;

  assign outs = {o_bs, o_al, o_ds, o_ro, o_rsto, o_dsc, o_dec, o_up};

  always #5 clk = ~clk;

  pcs_rx_link_sequencer dut (
    .i_clock               (clk),
    .i_reset               (rst_n),
    .i_enable              (en),
    .i_rf_stage_timeout    (tmo),
    .i_rf_backoff_cycles   (bko),
    .i_rf_clear_retry      (clr),
    .i_lanes_block_lock    (blk),
    .i_am_lock             (am),
    .i_invalid_skew        (skew),
    .i_hi_ber              (hiber),
    .o_enable_block_sync   (o_bs),
    .o_enable_aligner      (o_al),
    .o_enable_deskewer     (o_ds),
    .o_enable_lane_reorder (o_ro),
    .o_reset_order         (o_rsto),
    .o_enable_descrambler  (o_dsc),
    .o_enable_decoder      (o_dec),
    .o_link_up             (o_up),
    .o_state               (o_state),
    .o_retry_count         (o_retry)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; tmo = 24'd1000; bko = 16'd10; clr = 1'b0;
    blk = '0; am = '0; skew = 1'b0; hiber = '0;
    #2;
    checks++; if (outs !== E_OFF) begin failures++; $display("FAIL reset_outs got=%h exp=%h", outs, E_OFF); end
    checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    checks++; if (o_retry !== 8'd0) begin failures++; $display("FAIL reset_retry got=%0d exp=0", o_retry); end
    rst_n = 1'b1; en = 1'b1;
    step(1);
    checks++; if (o_state !== 3'd1 || outs !== E_BSYNC) begin failures++; $display("FAIL reset_release got=%0d/%h exp=1/%h", o_state, outs, E_BSYNC); end
  endtask

  task automatic test_bringup;
    step(18);
    checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL bsync_wait got=%0d exp=1", o_state); end
    blk = ALL;
    step(1);
    checks++; if (o_state !== 3'd2 || outs !== E_ALIGN) begin failures++; $display("FAIL bringup_align got=%0d/%h exp=2/%h", o_state, outs, E_ALIGN); end
    am = ALL;
    step(1);
    checks++; if (o_state !== 3'd3 || outs !== E_DESKEW) begin failures++; $display("FAIL bringup_deskew got=%0d/%h exp=3/%h", o_state, outs, E_DESKEW); end
    step(63);
    checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL settle_early got=%0d exp=3", o_state); end
    step(1);
    checks++; if (o_state !== 3'd4 || outs !== E_REORDER) begin failures++; $display("FAIL bringup_reorder got=%0d/%h exp=4/%h", o_state, outs, E_REORDER); end
    step(1);
    checks++; if (o_state !== 3'd5 || outs !== E_UP) begin failures++; $display("FAIL bringup_up got=%0d/%h exp=5/%h", o_state, outs, E_UP); end
    checks++; if (o_retry !== 8'd0) begin failures++; $display("FAIL bringup_retry got=%0d exp=0", o_retry); end
  endtask

  task automatic test_hi_ber;
    hiber = 20'h00080;
    step(1);
    hiber = '0;
    checks++; if (o_state !== 3'd6 || outs !== E_OFF) begin failures++; $display("FAIL hiber_backoff got=%0d/%h exp=6/%h", o_state, outs, E_OFF); end
    checks++; if (o_retry !== 8'd1) begin failures++; $display("FAIL hiber_retry got=%0d exp=1", o_retry); end
    step(10);
    checks++; if (o_state !== 3'd6) begin failures++; $display("FAIL backoff_len got=%0d exp=6", o_state); end
    step(1);
    checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL backoff_exit got=%0d exp=1", o_state); end
    step(2);
    checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL relock_deskew got=%0d exp=3", o_state); end
    step(65);
    checks++; if (o_state !== 3'd5 || o_up !== 1'b1) begin failures++; $display("FAIL relock_up got=%0d/%b exp=5/1", o_state, o_up); end
  endtask

  task automatic test_deskew_restart;
    en = 1'b0;
    step(1);
    checks++; if (o_state !== 3'd0 || outs !== E_OFF) begin failures++; $display("FAIL disable_idle got=%0d/%h exp=0/%h", o_state, outs, E_OFF); end
    en = 1'b1; am = '0;
    step(2);
    checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL skew_align got=%0d exp=2", o_state); end
    am = ALL;
    step(1);
    step(60);
    skew = 1'b1;
    step(1);
    skew = 1'b0;
    step(63);
    checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL skew_restart got=%0d exp=3", o_state); end
    step(1);
    checks++; if (o_state !== 3'd4) begin failures++; $display("FAIL skew_reorder got=%0d exp=4", o_state); end
    step(1);
    checks++; if (o_state !== 3'd5) begin failures++; $display("FAIL skew_up got=%0d exp=5", o_state); end
  endtask

  task automatic test_timeout_retry;
    tmo = 24'd50;
    blk = MISS; clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++; if (o_state !== 3'd6) begin failures++; $display("FAIL clr_fault_state got=%0d exp=6", o_state); end
    checks++; if (o_retry !== 8'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", o_retry); end
    step(11);
    step(50);
    checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL timeout_early got=%0d exp=1", o_state); end
    step(1);
    checks++; if (o_state !== 3'd6 || o_retry !== 8'd1) begin failures++; $display("FAIL timeout_fire got=%0d/%0d exp=6/1", o_state, o_retry); end
    for (int r = 2; r <= 256; r++) begin
      step(62);
      checks++; if (o_state !== 3'd6) begin failures++; $display("FAIL timeout_round%0d got=%0d exp=6", r, o_state); end
    end
    checks++; if (o_retry !== 8'd255) begin failures++; $display("FAIL retry_sat got=%0d exp=255", o_retry); end
    step(62);
    checks++; if (o_retry !== 8'd255) begin failures++; $display("FAIL retry_hold got=%0d exp=255", o_retry); end
  endtask

  task automatic test_timeout_vs_advance;
    blk = ALL; am = '0;
    step(12);
    step(50);
    checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL tva_align got=%0d exp=2", o_state); end
    am = ALL;
    step(1);
    checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL advance_wins got=%0d exp=3", o_state); end
  endtask

  task automatic test_enable_in_backoff;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++; if (o_retry !== 8'd0) begin failures++; $display("FAIL clear_retry got=%0d exp=0", o_retry); end
    blk = MISS;
    step(1);
    checks++; if (o_state !== 3'd6 || o_retry !== 8'd1) begin failures++; $display("FAIL deskew_loss got=%0d/%0d exp=6/1", o_state, o_retry); end
    en = 1'b0;
    step(1);
    checks++; if (o_state !== 3'd0 || outs !== E_OFF || o_retry !== 8'd1) begin failures++; $display("FAIL backoff_disable got=%0d/%h/%0d exp=0/%h/1", o_state, outs, o_retry, E_OFF); end
  endtask

  task automatic test_reset_mid_up;
    tmo = 24'd1000; en = 1'b1; blk = ALL; am = ALL;
    step(67);
    checks++; if (o_state !== 3'd4) begin failures++; $display("FAIL mid_reorder got=%0d exp=4", o_state); end
    step(1);
    checks++; if (o_state !== 3'd5 || outs !== E_UP) begin failures++; $display("FAIL mid_up got=%0d/%h exp=5/%h", o_state, outs, E_UP); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (outs !== E_OFF || o_state !== 3'd0 || o_retry !== 8'd0) begin failures++; $display("FAIL async_reset got=%h/%0d/%0d exp=%h/0/0", outs, o_state, o_retry, E_OFF); end
    step(1);
    checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", o_state); end
    #3 rst_n = 1'b1;
    step(1);
    checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL post_reset got=%0d exp=1", o_state); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_hi_ber();
    test_deskew_restart();
    test_timeout_retry();
    test_timeout_vs_advance();
    test_enable_in_backoff();
    test_reset_mid_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
